// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-centred hazard, forwarding and MDU sequencing control
// Optional perf counters (StallCnt, MDCnt) enabled by HAZ_PERF_CNT_EN.
module ex_hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = $clog2(MD_LAT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic [4:0] Rs_E,
  input  logic [4:0] Rt_E,
  input  logic [4:0] WriteReg_E,
  input  logic [4:0] WriteReg_M,
  input  logic [4:0] WriteReg_W,
  input  logic       RegWrite_E,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  input  logic       MemtoReg_E,
  input  logic       MemtoReg_M,
  input  logic       Branch_D,
  input  logic       MDStart_E,
  input  logic       MDRead_D,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       ForwardA_D,
  output logic       ForwardB_D,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Stall_E,
  output logic       Flush_E,
  output logic       MD_Go,
  output logic       MD_WriteHiLo,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0] StallCnt,
  output logic [31:0] MDCnt,
`endif
  output logic       MD_Busy
);

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lwstall, brstall, hlstall, mdstall;

  // $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  always_comb begin
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    if (RegWrite_M && reg_hit(WriteReg_M, Rs_E))      ForwardA_E = 2'b10;
    else if (RegWrite_W && reg_hit(WriteReg_W, Rs_E)) ForwardA_E = 2'b01;
    if (RegWrite_M && reg_hit(WriteReg_M, Rt_E))      ForwardB_E = 2'b10;
    else if (RegWrite_W && reg_hit(WriteReg_W, Rt_E)) ForwardB_E = 2'b01;
  end

  assign ForwardA_D = RegWrite_M && reg_hit(WriteReg_M, Rs_D);
  assign ForwardB_D = RegWrite_M && reg_hit(WriteReg_M, Rt_D);

  assign lwstall = MemtoReg_E && (reg_hit(WriteReg_E, Rs_D) || reg_hit(WriteReg_E, Rt_D));
  assign brstall = Branch_D &&
                   ((RegWrite_E && (reg_hit(WriteReg_E, Rs_D) || reg_hit(WriteReg_E, Rt_D))) ||
                    (MemtoReg_M && (reg_hit(WriteReg_M, Rs_D) || reg_hit(WriteReg_M, Rt_D))));
  assign hlstall = MDRead_D && ((state_q != MD_IDLE) || MDStart_E);
  assign mdstall = MDStart_E && (state_q != MD_IDLE);

  // A busy MDU freezes EX in place; other hazards insert a bubble into EX instead.
  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Flush_E = 1'b0;
    if (mdstall) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
    end else if (lwstall || brstall || hlstall) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    MD_Go        = 1'b0;
    MD_WriteHiLo = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (MDStart_E && !reset) begin
          MD_Go   = 1'b1;
          state_d = MD_RUN;
          cnt_d   = CNT_W'(MD_LAT - 1);
        end
      end
      MD_RUN: begin
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      MD_DONE: begin
        MD_WriteHiLo = 1'b1;
        state_d      = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign MD_Busy = (state_q != MD_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, md_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      md_cnt_q    <= '0;
    end else begin
      if (Stall_D) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (MD_Go)   md_cnt_q    <= md_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign MDCnt    = md_cnt_q;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - directed self-checking bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;
  localparam int MD_LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
  logic       RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
  logic       Branch_D, MDStart_E, MDRead_D;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       ForwardA_D, ForwardB_D, Stall_F, Stall_D, Stall_E, Flush_E;
  logic       MD_Go, MD_WriteHiLo, MD_Busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] StallCnt, MDCnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cyc, whl_cnt, whl_at, guard;

  ex_hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
    .clk(clk), .reset(reset),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M),
    .Branch_D(Branch_D), .MDStart_E(MDStart_E), .MDRead_D(MDRead_D),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Flush_E(Flush_E),
    .MD_Go(MD_Go), .MD_WriteHiLo(MD_WriteHiLo),
`ifdef HAZ_PERF_CNT_EN
    .StallCnt(StallCnt), .MDCnt(MDCnt),
`endif
    .MD_Busy(MD_Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs_D = 0; Rt_D = 0; Rs_E = 0; Rt_E = 0;
    WriteReg_E = 0; WriteReg_M = 0; WriteReg_W = 0;
    RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
    MemtoReg_E = 0; MemtoReg_M = 0;
    Branch_D = 0; MDStart_E = 0; MDRead_D = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    MDStart_E = 1'b1;
    #2;
    check("rst_go_masked", MD_Go, 0);
    check("rst_busy", MD_Busy, 0);
    check("rst_whl", MD_WriteHiLo, 0);
    check("rst_stall_d", Stall_D, 0);
    tick();
    reset = 1'b0;
    MDStart_E = 1'b0;
    #1;

    // forwarding
    RegWrite_M = 1; WriteReg_M = 5; RegWrite_W = 1; WriteReg_W = 5; Rs_E = 5; Rt_E = 0;
    #1;
    check("fwdA_M_prio", ForwardA_E, 2'b10);
    check("fwdB_r0", ForwardB_E, 2'b00);
    RegWrite_M = 0;
    #1;
    check("fwdA_W", ForwardA_E, 2'b01);
    Rt_E = 5;
    #1;
    check("fwdB_W", ForwardB_E, 2'b01);
    clear_inputs();
    RegWrite_M = 1; WriteReg_M = 0; Rs_E = 0;
    #1;
    check("fwdA_zero_reg", ForwardA_E, 2'b00);
    clear_inputs();

    // load-use
    MemtoReg_E = 1; WriteReg_E = 8; Rt_D = 8;
    #1;
    check("lw_stall_f", Stall_F, 1);
    check("lw_stall_d", Stall_D, 1);
    check("lw_flush_e", Flush_E, 1);
    check("lw_stall_e", Stall_E, 0);
    WriteReg_E = 0; Rt_D = 0;
    #1;
    check("lw_r0_nostall", Stall_D, 0);
    check("lw_r0_noflush", Flush_E, 0);
    clear_inputs();

    // branch compare
    Branch_D = 1; Rs_D = 3; RegWrite_E = 1; WriteReg_E = 3;
    #1;
    check("br_E_stall", Stall_D, 1);
    check("br_E_flush", Flush_E, 1);
    RegWrite_E = 0; WriteReg_E = 0; RegWrite_M = 1; WriteReg_M = 3;
    #1;
    check("br_M_nostall", Stall_D, 0);
    check("br_M_fwdA_D", ForwardA_D, 1);
    check("br_M_fwdB_D", ForwardB_D, 0);
    MemtoReg_M = 1;
    #1;
    check("br_Mload_stall", Stall_D, 1);
    clear_inputs();

    // single MDU op
    tick();
    MDStart_E = 1;
    #1;
    check("md_go", MD_Go, 1);
    check("md_go_busy0", MD_Busy, 0);
    tick();
    MDStart_E = 0;
    #1;
    busy_cyc = 0; whl_cnt = 0; whl_at = -1;
    for (int c = 1; c <= 8; c++) begin
      if (MD_Busy) busy_cyc++;
      if (MD_WriteHiLo) begin
        whl_cnt++;
        whl_at = c;
      end
      check($sformatf("md_nogo_c%0d", c), MD_Go, 0);
      tick();
      #1;
    end
    check("md_busy_cycles", busy_cyc, MD_LAT + 1);
    check("md_whl_count", whl_cnt, 1);
    check("md_whl_cycle", whl_at, MD_LAT + 1);
    check("md_idle_after", MD_Busy, 0);

    // back-to-back op held by mdstall, with mfhi and a load-use in decode
    MDStart_E = 1;
    #1;
    check("b2b_go1", MD_Go, 1);
    for (int c = 1; c <= MD_LAT + 1; c++) begin
      tick();
      MDRead_D = 1; MemtoReg_E = 1; WriteReg_E = 8; Rt_D = 8;
      #1;
      check($sformatf("b2b_stall_e_c%0d", c), Stall_E, 1);
      check($sformatf("b2b_stall_d_c%0d", c), Stall_D, 1);
      check($sformatf("b2b_flush_c%0d", c), Flush_E, 0);
      check($sformatf("b2b_nogo_c%0d", c), MD_Go, 0);
    end
    tick();
    #1;
    check("b2b_go2", MD_Go, 1);
    check("b2b_go2_stall_e", Stall_E, 0);
    check("b2b_go2_hl_stall_d", Stall_D, 1);
    check("b2b_go2_hl_flush", Flush_E, 1);
    tick();
    clear_inputs();
    #1;
    guard = 0;
    while (MD_Busy && guard < 20) begin
      tick();
      guard++;
    end
    check("b2b_drain", MD_Busy, 0);

    // reset during RUN
    MDStart_E = 1;
    tick();
    MDStart_E = 0;
    tick();
    #1;
    check("rst_run_busy_pre", MD_Busy, 1);
    reset = 1;
    #1;
    check("rst_run_busy", MD_Busy, 0);
    check("rst_run_whl", MD_WriteHiLo, 0);
    tick();
    reset = 0;
    whl_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (MD_WriteHiLo) whl_cnt++;
    end
    check("rst_run_no_whl", whl_cnt, 0);

`ifdef HAZ_PERF_CNT_EN
    reset = 1;
    #1;
    reset = 0;
    check("perf_stall_rst0", StallCnt, 0);
    check("perf_md_rst0", MDCnt, 0);
    tick();
    MDStart_E = 1;
    tick();
    MDStart_E = 0; MemtoReg_E = 1; WriteReg_E = 8; Rt_D = 8;
    tick();
    tick();
    tick();
    clear_inputs();
    #1;
    guard = 0;
    while (MD_Busy && guard < 20) begin
      tick();
      guard++;
    end
    check("perf_md_cnt", MDCnt, 1);
    check("perf_stall_cnt", StallCnt, 3);
    reset = 1;
    #1;
    check("perf_md_cnt_rst", MDCnt, 0);
    check("perf_stall_cnt_rst", StallCnt, 0);
    reset = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline, centred on the execution stage.
- Generates the 2-bit EX operand forwarding selects and the 1-bit decode-stage branch-compare forwarding selects.
- Generates stall/flush for load-use, branch-compare and HI/LO hazards.
- Sequences the iterative multiply/divide unit (MDU) in EX through a start/busy state machine, holding EX when a second mult/div arrives while the MDU is busy.

Parameters:
- MD_LAT, 32, number of RUN cycles the MDU needs per operation (>=1).
- CNT_W, $clog2(MD_LAT+1), width of the MDU cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Rs_D, Rt_D  in  5  source registers of the instruction in Decode.
- Rs_E, Rt_E  in  5  source registers of the instruction in Execute.
- WriteReg_E, WriteReg_M, WriteReg_W  in  5  destination registers in E/M/W.
- RegWrite_E, RegWrite_M, RegWrite_W  in  1  destination-write enables in E/M/W.
- MemtoReg_E, MemtoReg_M  in  1  instruction in E/M is a load.
- Branch_D  in  1  Decode holds a branch compared in Decode.
- MDStart_E  in  1  Execute holds mult/multu/div/divu.
- MDRead_D  in  1  Decode holds mfhi/mflo.
- ForwardA_E, ForwardB_E  out  2  00 = register file, 01 = Result_W, 10 = ALUOut_M; 11 is never driven.
- ForwardA_D, ForwardB_D  out  1  1 = forward ALUOut_M to the Decode comparator.
- Stall_F, Stall_D, Stall_E  out  1  hold the PC / IF-ID / ID-EX register.
- Flush_E  out  1  clear the ID-EX register to a bubble.
- MD_Go  out  1  one-cycle MDU start pulse.
- MD_WriteHiLo  out  1  MDU result valid; write HI/LO this cycle.
- MD_Busy  out  1  MDU state != IDLE.

Behaviour:
- Register $0 never matches: no forwarding and no stall when the compared register is 0.
- Forwarding (combinational):
  - ForwardA_E = 10 if RegWrite_M & WriteReg_M==Rs_E.
  - Else ForwardA_E = 01 if RegWrite_W & WriteReg_W==Rs_E.
  - Else ForwardA_E = 00.
  - ForwardB_E: same rules using Rt_E. M has priority over W.
  - ForwardA_D = RegWrite_M & WriteReg_M==Rs_D. ForwardB_D: same using Rt_D.
- Data hazard terms (combinational):
  - lwstall = MemtoReg_E & (WriteReg_E==Rs_D | WriteReg_E==Rt_D).
  - brstall = Branch_D & ( (RegWrite_E & WriteReg_E in {Rs_D,Rt_D}) | (MemtoReg_M & WriteReg_M in {Rs_D,Rt_D}) ).
  - hlstall = MDRead_D & (state!=IDLE | MDStart_E).
- MDU structural hazard: mdstall = MDStart_E & state!=IDLE.
- Output priority:
  - mdstall: Stall_F = Stall_D = Stall_E = 1, Flush_E = 0.
  - Else any of lwstall/brstall/hlstall: Stall_F = Stall_D = 1, Stall_E = 0, Flush_E = 1.
  - Else all four are 0.
- MDU FSM, states IDLE/RUN/DONE, registered state and counter:
  - IDLE: MD_Go = MDStart_E (combinational). On MD_Go, load cnt = MD_LAT-1 and go to RUN.
  - RUN: cnt decrements each cycle. When cnt==0, go to DONE.
  - DONE: MD_WriteHiLo = 1 for exactly one cycle, then IDLE.
  - Latency: Go edge, then MD_LAT RUN cycles, then 1 DONE cycle. MD_Busy is high for MD_LAT+1 cycles.
  - A mult/div held in EX by mdstall launches (MD_Go) in the first IDLE cycle after DONE.
  - The state==IDLE condition for MD_Go is sampled from the registered state, so no MD_Go can occur in DONE.
- Reset (asynchronous):
  - state = IDLE, cnt = 0; MD_Go, MD_WriteHiLo and MD_Busy read 0 for as long as reset is asserted (MD_Go masked during reset).
  - Stall/flush/forward outputs follow their combinational equations.
  - Reset mid-RUN or mid-DONE aborts the operation with no MD_WriteHiLo pulse.
- Simultaneous events:
  - mdstall and lwstall together: mdstall wins, and lwstall is re-evaluated once EX advances.
  - hlstall during DONE still stalls, because HI/LO is written at the end of the DONE cycle.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined:
  - Adds outputs StallCnt (out, 32) and MDCnt (out, 32).
  - StallCnt increments on each cycle with Stall_D=1.
  - MDCnt increments on each MD_Go.
  - Both reset to 0 and wrap at 2^32-1 → 0.
- When undefined: neither port nor logic exists, and behaviour is otherwise identical.

Test Plan:
- Forwarding: RegWrite_M=1, WriteReg_M=5; RegWrite_W=1, WriteReg_W=5; Rs_E=5, Rt_E=0 -> ForwardA_E=10, ForwardB_E=00; then drop RegWrite_M -> ForwardA_E=01.
- Load-use: MemtoReg_E=1, WriteReg_E=8, Rt_D=8 -> Stall_F=Stall_D=Flush_E=1, Stall_E=0; with WriteReg_E=0 and Rt_D=0 -> no stall.
- Branch: Branch_D=1, Rs_D=3, RegWrite_E=1, WriteReg_E=3 -> stall+flush. With the same writer in M as a non-load -> no stall and ForwardA_D=1.
- MDU sequence, MD_LAT=4: MDStart_E pulse -> MD_Go for 1 cycle, MD_Busy high 5 cycles, MD_WriteHiLo high on the 5th, then IDLE.
- Back-to-back mult/div with MD_LAT=4: second MDStart_E held -> Stall_E=1 for 5 cycles, MD_Go on the next cycle. Meanwhile MDRead_D=1 -> Stall_D high and Flush_E=0 while mdstall is active.
- Reset on the 2nd RUN cycle -> MD_Busy=0 immediately and no MD_WriteHiLo pulse. With HAZ_PERF_CNT_EN defined, after one op with 3 stall cycles -> MDCnt=1, StallCnt=3, and both read 0 after reset.
